// File: rtl/bram_port_initiator_if.sv
// Request, response and RAM-port bundle for bram_port_initiator.
// slave is the initiator's own view; master is the view of whatever drives and observes it.
interface bram_port_initiator_if #(
    parameter int LINES = 4096
);
    localparam int AW = $clog2(LINES);

    logic          req_valid;
    logic          req_ready;
    logic [31:0]   req_addr;
    logic          req_store;
    logic [1:0]    req_size;
    logic          req_signed;
    logic [31:0]   req_wdata;
    logic [3:0]    req_id;

    logic          resp_valid;
    logic          resp_ready;
    logic [31:0]   resp_data;
    logic [3:0]    resp_id;
    logic          resp_misaligned;

    logic [AW-1:0] ram_addr;
    logic          ram_en;
    logic [3:0]    ram_be;
    logic [31:0]   ram_wdata;
    logic [31:0]   ram_rdata;

    modport slave (
        input  req_valid, req_addr, req_store, req_size, req_signed, req_wdata, req_id,
        input  resp_ready, ram_rdata,
        output req_ready, resp_valid, resp_data, resp_id, resp_misaligned,
        output ram_addr, ram_en, ram_be, ram_wdata
    );

    modport master (
        output req_valid, req_addr, req_store, req_size, req_signed, req_wdata, req_id,
        output resp_ready, ram_rdata,
        input  req_ready, resp_valid, resp_data, resp_id, resp_misaligned,
        input  ram_addr, ram_en, ram_be, ram_wdata
    );
endinterface

// File: rtl/bram_port_initiator.sv
// LSU-to-byte-enable-BRAM initiator: lane steering, one-cycle read alignment and a credit-limited response FIFO.
// Define BRAM_PORT_STATS_EN to add the load/store/stall statistics counters.
module bram_port_initiator #(
    parameter int LINES      = 4096,
    parameter int RESP_DEPTH = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    bram_port_initiator_if.slave bus
`ifdef BRAM_PORT_STATS_EN
    ,
    output logic [31:0]          o_stat_loads,
    output logic [31:0]          o_stat_stores,
    output logic [31:0]          o_stat_stall
`endif
);
    localparam int AW    = $clog2(LINES);
    localparam int PW    = $clog2(RESP_DEPTH);
    localparam int CNT_W = $clog2(RESP_DEPTH + 1);
    localparam int CW    = CNT_W + 1;

    logic             w_req_ready;
    logic             w_accept;
    logic             w_mis;
    logic [1:0]       w_off;
    logic [3:0]       w_be;
    logic [31:0]      w_wdata;
    logic             w_push;
    logic             w_pop;
    logic [CW-1:0]    w_used;
    logic [31:0]      w_shift;
    logic [31:0]      w_fmt;

    logic             r_s1_valid;
    logic [3:0]       r_s1_id;
    logic [1:0]       r_s1_off;
    logic [1:0]       r_s1_size;
    logic             r_s1_signed;
    logic             r_s1_store;
    logic             r_s1_mis;

    logic [31:0]      r_fifo_data [RESP_DEPTH];
    logic [3:0]       r_fifo_id   [RESP_DEPTH];
    logic             r_fifo_mis  [RESP_DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CNT_W-1:0] r_count;

    // Explicit wrap so non-power-of-2 depths cycle correctly.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        if (p == PW'(RESP_DEPTH - 1)) begin
            return {PW{1'b0}};
        end else begin
            return p + PW'(1);
        end
    endfunction

    generate
        if (2 + AW < 32) begin : g_addr_unused
            logic w_unused_addr;
            assign w_unused_addr = ^bus.req_addr[31:2+AW];
        end
    endgenerate

    // Credit: count what will occupy the FIFO once s1 lands, net of this cycle's pop.
    assign w_pop       = (r_count != CNT_W'(0)) && bus.resp_ready;
    assign w_push      = r_s1_valid;
    assign w_used      = CW'(r_count) + CW'(r_s1_valid) - CW'(w_pop);
    assign w_req_ready = i_rst_n && (w_used < CW'(RESP_DEPTH));
    assign w_accept    = bus.req_valid && w_req_ready;
    assign w_off       = bus.req_addr[1:0];

    assign bus.req_ready = w_req_ready;
    assign bus.ram_addr  = bus.req_addr[2 +: AW];
    assign bus.ram_en    = w_accept && !w_mis;
    assign bus.ram_be    = bus.ram_en ? w_be : 4'h0;
    assign bus.ram_wdata = w_wdata;

    // Alignment check per access size.
    always_comb begin
        w_mis = 1'b0;
        case (bus.req_size)
            2'd0:    w_mis = 1'b0;
            2'd1:    w_mis = bus.req_addr[0];
            2'd2:    w_mis = (w_off != 2'd0);
            default: w_mis = 1'b1;
        endcase
    end

    // Store lane enables and data replication.
    always_comb begin
        w_be    = 4'h0;
        w_wdata = bus.req_wdata;
        if (bus.req_store) begin
            case (bus.req_size)
                2'd0: begin
                    w_be    = 4'b0001 << w_off;
                    w_wdata = {4{bus.req_wdata[7:0]}};
                end
                2'd1: begin
                    w_be    = 4'b0011 << w_off;
                    w_wdata = {2{bus.req_wdata[15:0]}};
                end
                2'd2: begin
                    w_be    = 4'hF;
                    w_wdata = bus.req_wdata;
                end
                default: begin
                    w_be    = 4'h0;
                    w_wdata = bus.req_wdata;
                end
            endcase
        end else begin
            w_be    = 4'h0;
            w_wdata = bus.req_wdata;
        end
    end

    assign w_shift = bus.ram_rdata >> {r_s1_off, 3'b000};

    // Load formatting; stores and faults never return RAM contents.
    always_comb begin
        w_fmt = 32'h0;
        if (r_s1_store || r_s1_mis) begin
            w_fmt = 32'h0;
        end else begin
            case (r_s1_size)
                2'd0:    w_fmt = r_s1_signed ? {{24{w_shift[7]}}, w_shift[7:0]}
                                             : {24'h0, w_shift[7:0]};
                2'd1:    w_fmt = r_s1_signed ? {{16{w_shift[15]}}, w_shift[15:0]}
                                             : {16'h0, w_shift[15:0]};
                default: w_fmt = w_shift;
            endcase
        end
    end

    // Stage s1: request attributes aligned with the RAM's read latency.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_s1_valid  <= 1'b0;
            r_s1_id     <= 4'h0;
            r_s1_off    <= 2'd0;
            r_s1_size   <= 2'd0;
            r_s1_signed <= 1'b0;
            r_s1_store  <= 1'b0;
            r_s1_mis    <= 1'b0;
        end else begin
            r_s1_valid <= w_accept;
            if (w_accept) begin
                r_s1_id     <= bus.req_id;
                r_s1_off    <= w_off;
                r_s1_size   <= bus.req_size;
                r_s1_signed <= bus.req_signed;
                r_s1_store  <= bus.req_store;
                r_s1_mis    <= w_mis;
            end
        end
    end

    // FIFO pointers and occupancy.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= {PW{1'b0}};
            r_rd_ptr <= {PW{1'b0}};
            r_count  <= {CNT_W{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // FIFO storage; contents are meaningless while the count is zero.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= w_fmt;
            r_fifo_id[r_wr_ptr]   <= r_s1_id;
            r_fifo_mis[r_wr_ptr]  <= r_s1_mis;
        end
    end

    assign bus.resp_valid      = (r_count != CNT_W'(0));
    assign bus.resp_data       = r_fifo_data[r_rd_ptr];
    assign bus.resp_id         = r_fifo_id[r_rd_ptr];
    assign bus.resp_misaligned = r_fifo_mis[r_rd_ptr];

`ifdef BRAM_PORT_STATS_EN
    logic [31:0] r_stat_loads;
    logic [31:0] r_stat_stores;
    logic [31:0] r_stat_stall;

    // Statistics counters, free-running with natural 32-bit wrap.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stat_loads  <= 32'h0;
            r_stat_stores <= 32'h0;
            r_stat_stall  <= 32'h0;
        end else begin
            if (bus.ram_en && !bus.req_store) begin
                r_stat_loads <= r_stat_loads + 32'd1;
            end
            if (bus.ram_en && bus.req_store) begin
                r_stat_stores <= r_stat_stores + 32'd1;
            end
            if (bus.req_valid && !w_req_ready) begin
                r_stat_stall <= r_stat_stall + 32'd1;
            end
        end
    end

    assign o_stat_loads  = r_stat_loads;
    assign o_stat_stores = r_stat_stores;
    assign o_stat_stall  = r_stat_stall;
`else
`endif

endmodule

// File: doc/bram_port_initiator.md
Name: bram_port_initiator

Overview:
- Initiator side of the byte-enable local-memory port. Converts a valid/ready load/store request stream from the load-store path into single-port byte-enable RAM accesses.
- Handles the RAM's one-cycle registered read latency, byte-lane steering, store data replication and load sign/zero extension.
- Returns in-order responses through a credit-limited response FIFO.
- Sits between the LSU and one port of the local byte-enable block RAM.

Parameters:
- LINES, 4096, number of 32-bit RAM words; ram_addr width is $clog2(LINES).
- RESP_DEPTH, 2, response FIFO entries; minimum 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request valid.
- req_ready  out  1  request accepted when valid and ready are both high.
- req_addr  in  32  byte address.
- req_store  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word, 3 = reserved.
- req_signed  in  1  sign-extend loads.
- req_wdata  in  32  store data, right-aligned.
- req_id  in  4  tag echoed on the response.
- resp_valid  out  1  response valid.
- resp_ready  in  1  response consumed.
- resp_data  out  32  load result; 0 for stores and faults.
- resp_id  out  4  echoed tag.
- resp_misaligned  out  1  request faulted; no RAM access was made.
- ram_addr  out  $clog2(LINES)  word address = req_addr[2 +: $clog2(LINES)]; upper address bits are ignored.
- ram_en  out  1  RAM port enable.
- ram_be  out  4  byte write enables.
- ram_wdata  out  32  RAM write data.
- ram_rdata  in  32  RAM read data, valid one cycle after ram_en.

Behaviour:
- Accept occurs in cycle N when req_valid && req_ready.
- RAM drive (combinational):
  - ram_en = accept && !misaligned.
  - ram_be = 0 for loads.
  - Store byte: ram_be = 1<<off.
  - Store half: ram_be = 3<<off.
  - Store word: ram_be = 4'hF.
  - off = req_addr[1:0].
- Store data is replicated across lanes: byte x4, half x2, word as-is.
- Misaligned when any of: size 1 with addr[0]=1; size 2 with addr[1:0]!=0; size 3. Misaligned requests give ram_en=0 and still produce a response.
- Stage register s1: on accept, captures {id, off, size, signed, store, misaligned}; s1_valid is set.
- Cycle N+1 format step:
  - Shift ram_rdata right by 8*off.
  - Extend from bit 7 (byte) or bit 15 (half) when signed; otherwise zero-extend.
  - Force data to 0 for stores and faults.
  - Push the result into the FIFO.
- resp_valid is asserted from FIFO non-empty. Load-to-response latency is 2 cycles (resp_valid high in N+2).
- Responses are strictly in request order; every accepted request yields exactly one response.
- Credit: req_ready = (fifo_count + s1_valid − pop) < RESP_DEPTH, where pop = resp_valid && resp_ready. req_ready therefore depends combinationally on resp_ready.
- Full throughput (1 request/cycle) holds with resp_ready held high at RESP_DEPTH=2.
- Backpressure: with resp_ready low, at most RESP_DEPTH requests are outstanding. The FIFO never overflows, and no response is lost or duplicated.
- FIFO pointers wrap modulo RESP_DEPTH, including non-power-of-2 depths.
- Simultaneous push and pop on a full FIFO is legal and leaves the count unchanged.
- Store response data is 0 regardless of the RAM's write-first read-back.
- Reset (asynchronous, any cycle):
  - s1_valid=0, FIFO empty, resp_valid=0.
  - req_ready=0 while rst_n is low.
  - ram_en=0 and ram_be=0 while rst_n is low.
  - In-flight requests are discarded.
  - After release, req_ready=1 in the first clock.

Optional Feature:
- BRAM_PORT_STATS_EN, defined: adds outputs stat_loads[31:0], stat_stores[31:0] and stat_stall[31:0].
  - stat_loads increments on each accepted aligned load.
  - stat_stores increments on each accepted aligned store.
  - stat_stall increments on each cycle with req_valid && !req_ready.
  - All counters wrap at 2^32 and clear on reset.
- BRAM_PORT_STATS_EN, undefined: the ports and counters are absent; behaviour is otherwise identical.

Test Plan:
- Store word 0xDEADBEEF at addr 0x10, then load word at 0x10 → ram_be=F, ram_addr=4; resp_data=0xDEADBEEF, resp_id matches, 2-cycle latency.
- Store byte 0x80 at 0x13, then load byte signed at 0x13 → ram_be=8, ram_wdata=0x80808080; response 0xFFFFFF80. Unsigned load → 0x00000080.
- Load half at 0x21 and word at 0x22 → resp_misaligned=1, resp_data=0, ram_en never asserted; ids preserved in order.
- Back-to-back 8 loads with resp_ready=1 → req_ready stays 1, responses arrive every cycle in id order 0..7.
- resp_ready=0 with continuous requests → exactly RESP_DEPTH accepted, then req_ready=0. Releasing resp_ready drains all responses in order with no loss.
- Assert rst_n low with 2 responses pending → resp_valid=0 immediately, req_ready=0. After release the FIFO is empty and req_ready=1. With BRAM_PORT_STATS_EN, counters read 0.
